// File: rtl/vga_timing_generator.sv
// VGA raster timing: prescaler, h/v counters, per-axis phase FSMs and registered
// outputs hsync/vsync/visible/blank_n/sync_n/x/y/frame_start/pixel_tick.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int CLK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        blank_n,
  output logic        sync_n,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_A_END = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_F_END = 11'(H_ACTIVE + H_FRONT - 1);
  localparam logic [10:0] H_S_END = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);

  localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  logic [1:0]  div_q, div_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  phase_e      h_state_q, h_state_d;
  phase_e      v_state_q, v_state_d;

  logic        tick;
  logic        line_wrap;
  logic        v_adv;

  logic        vis_q, vis_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic        pt_q, pt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;

  assign tick      = (div_q == DIV_LAST);
  assign line_wrap = (h_cnt_q == H_LAST);
  assign v_adv     = tick && line_wrap;

  always_comb begin
    div_d = tick ? 2'd0 : div_q + 2'd1;
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (tick) begin
      h_cnt_d = line_wrap ? 11'd0 : h_cnt_q + 11'd1;
    end
  end

  always_comb begin
    v_cnt_d = v_cnt_q;
    if (v_adv) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= 2'd0;
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 10'd0;
      h_state_q <= PH_ACTIVE;
      v_state_q <= PH_ACTIVE;
    end else begin
      div_q     <= div_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  // Horizontal phase: leave a phase on the tick at its last column
  always_comb begin
    h_state_d = h_state_q;
    if (tick) begin
      unique case (h_state_q)
        PH_ACTIVE: if (h_cnt_q == H_A_END) h_state_d = PH_FRONT;
        PH_FRONT:  if (h_cnt_q == H_F_END) h_state_d = PH_SYNC;
        PH_SYNC:   if (h_cnt_q == H_S_END) h_state_d = PH_BACK;
        PH_BACK:   if (h_cnt_q == H_LAST)  h_state_d = PH_ACTIVE;
      endcase
    end
  end

  // Vertical phase: same scheme, advancing only at line wrap
  always_comb begin
    v_state_d = v_state_q;
    if (v_adv) begin
      unique case (v_state_q)
        PH_ACTIVE: if (v_cnt_q == V_A_END) v_state_d = PH_FRONT;
        PH_FRONT:  if (v_cnt_q == V_F_END) v_state_d = PH_SYNC;
        PH_SYNC:   if (v_cnt_q == V_S_END) v_state_d = PH_BACK;
        PH_BACK:   if (v_cnt_q == V_LAST)  v_state_d = PH_ACTIVE;
      endcase
    end
  end

  // Output decode from the pre-advance counters and states
  always_comb begin
    vis_d = (h_state_q == PH_ACTIVE) && (v_state_q == PH_ACTIVE);
    hs_d  = (h_state_q != PH_SYNC);
    vs_d  = (v_state_q != PH_SYNC);
    x_d   = vis_d ? h_cnt_q : 11'd0;
    y_d   = vis_d ? v_cnt_q : 10'd0;
    pt_d  = tick;
    fs_d  = vis_d && (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0) && tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vis_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      x_q   <= 11'd0;
      y_q   <= 10'd0;
      pt_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      vis_q <= vis_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      x_q   <= x_d;
      y_q   <= y_d;
      pt_q  <= pt_d;
      fs_q  <= fs_d;
    end
  end

  assign pixel_tick  = pt_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign visible     = vis_q;
  assign blank_n     = vis_q;
  assign sync_n      = 1'b0;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default timing at CLK_DIV 1 and 2,
// plus a reduced-size raster for frame-level, wrap and mid-frame reset checks.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  logic pt_a, hs_a, vs_a, vis_a, bn_a, sn_a, fs_a;
  logic pt_b, hs_b, vs_b, vis_b, bn_b, sn_b, fs_b;
  logic pt_c, hs_c, vs_c, vis_c, bn_c, sn_c, fs_c;
  logic [10:0] x_a, x_b, x_c;
  logic [9:0]  y_a, y_b, y_c;

  // A: default 640x480, CLK_DIV=1
  vga_timing_generator u_a (
    .clk(clk), .reset(rst_a), .pixel_tick(pt_a), .hsync(hs_a),
    .vsync(vs_a), .visible(vis_a), .blank_n(bn_a), .sync_n(sn_a),
    .x(x_a), .y(y_a), .frame_start(fs_a)
  );

  // B: 8+2+3+2=15 columns, 4+2+2+3=11 lines, 165 clks per frame
  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
  ) u_b (
    .clk(clk), .reset(rst_b), .pixel_tick(pt_b), .hsync(hs_b),
    .vsync(vs_b), .visible(vis_b), .blank_n(bn_b), .sync_n(sn_b),
    .x(x_b), .y(y_b), .frame_start(fs_b)
  );

  // C: default timing, CLK_DIV=2
  vga_timing_generator #(.CLK_DIV(2)) u_c (
    .clk(clk), .reset(rst_c), .pixel_tick(pt_c), .hsync(hs_c),
    .vsync(vs_c), .visible(vis_c), .blank_n(bn_c), .sync_n(sn_c),
    .x(x_c), .y(y_c), .frame_start(fs_c)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   dut;
    int   n;
    logic vis;
    logic hs;
    logic vs;
    logic fs;
    logic pt;
    int   x;
    int   y;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic get(input int d, output logic vis, output logic hs,
                     output logic vs, output logic fs, output logic pt,
                     output logic bn, output logic sn,
                     output int x, output int y);
    case (d)
      0: begin
        vis = vis_a; hs = hs_a; vs = vs_a; fs = fs_a; pt = pt_a;
        bn = bn_a; sn = sn_a; x = int'(x_a); y = int'(y_a);
      end
      1: begin
        vis = vis_b; hs = hs_b; vs = vs_b; fs = fs_b; pt = pt_b;
        bn = bn_b; sn = sn_b; x = int'(x_b); y = int'(y_b);
      end
      default: begin
        vis = vis_c; hs = hs_c; vs = vs_c; fs = fs_c; pt = pt_c;
        bn = bn_c; sn = sn_c; x = int'(x_c); y = int'(y_c);
      end
    endcase
  endtask

  task automatic chk_all(input string tag, input int d, input logic evis,
                         input logic ehs, input logic evs, input logic efs,
                         input logic ept, input int ex, input int ey);
    logic vis, hs, vs, fs, pt, bn, sn;
    int x, y;
    get(d, vis, hs, vs, fs, pt, bn, sn, x, y);
    chk({tag, " visible"}, 32'(vis), 32'(evis));
    chk({tag, " hsync"}, 32'(hs), 32'(ehs));
    chk({tag, " vsync"}, 32'(vs), 32'(evs));
    chk({tag, " frame_start"}, 32'(fs), 32'(efs));
    chk({tag, " pixel_tick"}, 32'(pt), 32'(ept));
    chk({tag, " blank_n"}, 32'(bn), 32'(evis));
    chk({tag, " sync_n"}, 32'(sn), 32'd0);
    chk({tag, " x"}, 32'(x), 32'(ex));
    chk({tag, " y"}, 32'(y), 32'(ey));
  endtask

  task automatic chk_rst(input string tag, input int d);
    chk_all(tag, d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // Reference timing of B, n = edges since reset release
  task automatic model_b(input int n, output logic vis, output logic hs,
                         output logic vs, output logic fs,
                         output int x, output int y);
    int p, h, v;
    p   = (n - 1) % 165;
    h   = p % 15;
    v   = p / 15;
    vis = (h < 8) && (v < 4);
    hs  = !((h >= 10) && (h < 13));
    vs  = !((v >= 6) && (v < 8));
    fs  = (p == 0);
    x   = vis ? h : 0;
    y   = vis ? v : 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errA, errC, hsl, fsc, vslB, vsFirstB;
    int fsq[$];
    logic mv, mh, mvs, mf;
    int mx, my;

    // dut, n, vis, hs, vs, fs, pt, x, y
    vt.push_back('{0,    1, 1, 1, 1, 1, 1,   0, 0});
    vt.push_back('{0,    2, 1, 1, 1, 0, 1,   1, 0});
    vt.push_back('{0,  640, 1, 1, 1, 0, 1, 639, 0});
    vt.push_back('{0,  641, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{0,  656, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{0,  657, 0, 0, 1, 0, 1,   0, 0});
    vt.push_back('{0,  752, 0, 0, 1, 0, 1,   0, 0});
    vt.push_back('{0,  753, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{0,  800, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{0,  801, 1, 1, 1, 0, 1,   0, 1});
    vt.push_back('{0, 1000, 1, 1, 1, 0, 1, 199, 1});
    vt.push_back('{0, 1441, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{1,   16, 1, 1, 1, 0, 1,   0, 1});
    vt.push_back('{1,  165, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{1,  166, 1, 1, 1, 1, 1,   0, 0});
    vt.push_back('{1,  331, 1, 1, 1, 1, 1,   0, 0});
    vt.push_back('{2,    1, 1, 1, 1, 0, 0,   0, 0});
    vt.push_back('{2,    2, 1, 1, 1, 1, 1,   0, 0});
    vt.push_back('{2,    3, 1, 1, 1, 0, 0,   1, 0});
    vt.push_back('{2, 1280, 1, 1, 1, 0, 1, 639, 0});
    vt.push_back('{2, 1281, 0, 1, 1, 0, 0,   0, 0});
    vt.push_back('{2, 1312, 0, 1, 1, 0, 1,   0, 0});
    vt.push_back('{2, 1313, 0, 0, 1, 0, 0,   0, 0});
    vt.push_back('{2, 1504, 0, 0, 1, 0, 1,   0, 0});
    vt.push_back('{2, 1505, 0, 1, 1, 0, 0,   0, 0});
    vt.push_back('{2, 1601, 1, 1, 1, 0, 0,   0, 1});
    vt.push_back('{2, 1602, 1, 1, 1, 0, 1,   0, 1});

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_rst($sformatf("rstA%0d", i), 0);
      chk_rst($sformatf("rstB%0d", i), 1);
      chk_rst($sformatf("rstC%0d", i), 2);
    end

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    errA = 0; errC = 0; hsl = 0; fsc = 0; vslB = 0; vsFirstB = 0;

    for (int n = 1; n <= 1700; n++) begin
      step();
      foreach (vt[i]) begin
        if (vt[i].n == n) begin
          chk_all($sformatf("vec d%0d n%0d", vt[i].dut, n), vt[i].dut,
                  vt[i].vis, vt[i].hs, vt[i].vs, vt[i].fs, vt[i].pt,
                  vt[i].x, vt[i].y);
        end
      end
      if (vs_a !== 1'b1 || pt_a !== 1'b1) errA++;
      if (bn_a !== vis_a || sn_a !== 1'b0) errA++;
      if (n <= 640 && (vis_a !== 1'b1 || int'(x_a) != n - 1)) errA++;
      if (pt_c !== ((n % 2) == 0)) errC++;
      if (n <= 1600) begin
        if (hs_c === 1'b0) hsl++;
        if (fs_c === 1'b1) fsc++;
      end
      model_b(n, mv, mh, mvs, mf, mx, my);
      chk_all($sformatf("modelB n%0d", n), 1, mv, mh, mvs, mf, 1'b1,
              mx, my);
      if (fs_b === 1'b1) fsq.push_back(n);
      if (n <= 165 && vs_b === 1'b0) begin
        vslB++;
        if (vsFirstB == 0) vsFirstB = n;
      end
    end

    chk("A_line_aggregate_errors", 32'(errA), 32'd0);
    chk("C_tick_alternation_errors", 32'(errC), 32'd0);
    chk("C_hsync_low_clks", 32'(hsl), 32'd192);
    chk("C_frame_start_pulses", 32'(fsc), 32'd1);
    chk("B_vsync_low_clks", 32'(vslB), 32'd30);
    chk("B_vsync_first_low_edge", 32'(vsFirstB), 32'd91);
    chk("B_frame_start_count", 32'(fsq.size()), 32'd11);
    if (fsq.size() >= 2) begin
      chk("B_frame_period", 32'(fsq[1] - fsq[0]), 32'd165);
    end

    // B is now at line 3, column 4: abort mid-frame
    chk("B_pre_reset_x", 32'(x_b), 32'd4);
    rst_b = 1'b0;
    #1;
    chk_rst("midrst_async", 1);
    step();
    chk_rst("midrst_hold1", 1);
    step();
    chk_rst("midrst_hold2", 1);
    rst_b = 1'b1;
    step();
    chk_all("midrst_edge1", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    step();
    chk_all("midrst_edge2", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Generates raster timing for the VGA output path.
- Produces hsync, vsync and visible, which the downstream image controller uses to derive pixel coordinates and frame-buffer addresses.
- Also produces DAC-side strobes (blank_n, sync_n), pixel coordinates and a frame-start pulse.
- Default timing is 640x480 at 60 Hz with a 25 MHz pixel rate; all timing is parameterised.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 1, clk cycles per pixel (1..4); consumers that count visible once per clk require 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
pixel_tick  output  1  one-clk pulse marking each pixel slot; constant 1 when CLK_DIV=1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
visible  output  1  high while the current pixel is inside the active area
blank_n  output  1  equal to visible (DAC blank, active low)
sync_n  output  1  constant 0 (composite sync unused)
x  output  11  active-area column (0..H_ACTIVE-1); held at 0 outside the active area
y  output  10  active-area line (0..V_ACTIVE-1); held at 0 outside the active area
frame_start  output  1  one-clk pulse coinciding with the first visible pixel of each frame

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (525).
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick is high when div_cnt == CLK_DIV-1; with CLK_DIV=1, tick is always high.
- Horizontal counter h_cnt, 11 bits, range 0..H_TOTAL-1:
  - Increments on tick.
  - At H_TOTAL-1 it wraps to 0 and asserts line_wrap.
- Vertical counter v_cnt, 10 bits, range 0..V_TOTAL-1:
  - Increments only on a tick that has line_wrap.
  - Wraps to 0 after V_TOTAL-1.
- Phase FSMs: one per axis, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Transitions happen when the axis counter reaches the last value of the current phase, and only on that axis's advance condition.
  - Phase boundaries (horizontal): ACTIVE ends at H_ACTIVE-1, FRONT ends at H_ACTIVE+H_FRONT-1, SYNC ends at H_ACTIVE+H_FRONT+H_SYNC-1, BACK ends at H_TOTAL-1. Vertical uses the same scheme with V_* parameters.
  - The FSM state must always agree with the counter; any mismatch is an error (the bench checks it).
- Output registers, updated every clk (one clk latency):
  - visible = (h_state==ACTIVE && v_state==ACTIVE)
  - hsync = !(h_state==SYNC)
  - vsync = !(v_state==SYNC)
  - x = visible ? h_cnt : 0
  - y = visible ? v_cnt : 0
  - pixel_tick = tick
  - frame_start = visible && h_cnt==0 && v_cnt==0 && tick
  - All values are taken from the pre-advance counter and state of the same cycle.
- With CLK_DIV>1, each output value holds for CLK_DIV clks. frame_start pulses only on the clk whose tick is set.
- Reset (asynchronous, reset=0):
  - Counters, div_cnt, FSMs: h_cnt=0, v_cnt=0, div_cnt=0, both FSMs in ACTIVE.
  - Outputs: hsync=1, vsync=1, visible=0, blank_n=0, x=0, y=0, frame_start=0, pixel_tick=0.
  - sync_n is 0 at all times.
  - Reset asserted mid-line or mid-frame aborts immediately. The next frame restarts at (0,0) on the first clk after release; no partial-frame recovery.
- Simultaneous events:
  - On the tick at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, both counters wrap in the same clk.
  - The next output cycle is frame_start.
- The downstream consumer relies on two properties:
  - hsync falling once per line, after visible has fallen.
  - vsync falling once per frame, during vertical front/back separation.
  - The parameter ordering above guarantees both.

Test Plan:
- Reset values: hold reset=0 for 5 clks -> hsync=1, vsync=1, visible=0, blank_n=0, x=0, y=0, frame_start=0, sync_n=0 throughout.
- First line, CLK_DIV=1: release reset.
  - visible high on clk edges 1..640, frame_start only on edge 1, x counts 0..639.
  - visible low on edges 641..800.
  - hsync low on edges 657..752; high elsewhere.
  - Line period 800 clks; y=1 on the visible pixels of line 2.
- Vertical timing, CLK_DIV=1: run a full frame.
  - vsync low for exactly 1600 clks, starting at line 490.
  - visible never high during lines 480..524.
  - Next frame_start occurs exactly 420000 clks after the previous one.
- Wrap/simultaneous: observe the edges around h_cnt=799, v_cnt=524.
  - Next output edge: x=0, y=0, visible=1, frame_start=1.
  - No spurious vsync or hsync glitch at the wrap.
- CLK_DIV=2:
  - pixel_tick alternates 0/1.
  - Each output holds 2 clks.
  - hsync low for 192 clks; line period 1600 clks.
  - frame_start is a single 1-clk pulse per frame.
- Reset mid-frame: assert reset at line 300, x=123.
  - Outputs return to reset values within the same cycle.
  - After release, the first visible pixel is x=0, y=0 with frame_start=1 on edge 1.
